// File: rtl/mult_arbiter.sv
// Purpose: round-robin arbiter sharing one unsigned multiplier (fast_mult) among N requesters.
// Latency: request accepted at edge t, product registered at t+1, resp_valid high from edge t+2.
// Backpressure: holds RESP (and refuses new requests) until the owner asserts resp_ready.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (req_ready one-hot or zero)
//   req_lhs/req_rhs       packed operands, requester i in bits [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready per-requester response handshake (resp_valid one-hot or zero)
//   resp_data             registered 2*WIDTH product, shared by all requesters
//   busy                  high while a transaction is in MUL or RESP

// Combinational unsigned multiplier: sum of shifted partial products.
module fast_mult #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) begin
        acc = acc + ({{WIDTH{1'b0}}, a} << i);
      end
    end
    p = acc;
  end

endmodule

module mult_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_lhs,
  input  logic [N*WIDTH-1:0]   req_rhs,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ready,
  output logic [2*WIDTH-1:0]   resp_data,
  output logic                 busy
);

  localparam int PW = $clog2(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
  } op_t;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  op_t                op_q, op_d;
  logic [2*WIDTH-1:0] resp_data_q, resp_data_d;

  logic               grant_vld;
  logic [PW-1:0]      grant_id;
  logic [PW:0]        cand;
  op_t                grant_op;
  logic [2*WIDTH-1:0] product;
  logic               accept;

  // Cyclic search starting at rr_ptr; cand carries one extra bit so the
  // wrap can be done by a single compare/subtract for any N.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
      if (!grant_vld && req_valid[cand[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    grant_op.lhs = req_lhs[int'(grant_id)*WIDTH +: WIDTH];
    grant_op.rhs = req_rhs[int'(grant_id)*WIDTH +: WIDTH];
  end

  // Ready is only offered from IDLE and never while reset is asserted, so a
  // requester cannot believe it was accepted on a cycle that gets discarded.
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && !reset && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept = (state_q == ST_IDLE) && grant_vld && !reset;

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_RESP) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  fast_mult #(.WIDTH(WIDTH)) u_fast_mult (
    .a (op_q.lhs),
    .b (op_q.rhs),
    .p (product)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = grant_op;
          owner_d = grant_id;
          if (grant_id == PW'(N-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_id + PW'(1);
          end
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        resp_data_d = product;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Only the owner's resp_ready matters; resp_data stays put afterwards.
        if (resp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      op_q        <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_data = resp_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Purpose: directed self-checking bench for mult_arbiter (N=4, WIDTH=4).
// Latency: checks exact cycle timing of accept, MUL and RESP phases.
// Backpressure: exercises held RESP with resp_ready low on the owner.
module tb_mult_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_lhs;
  logic [15:0] req_rhs;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [7:0]  resp_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.N(4), .WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] l, input logic [3:0] r);
    req_lhs[i*4 +: 4] = l;
    req_rhs[i*4 +: 4] = r;
    req_valid[i]      = 1'b1;
  endtask

  // One full transaction for requester g with resp_ready held high:
  // IDLE accept cycle, MUL cycle, RESP cycle.
  task automatic serve(input int g, input logic [7:0] p);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", resp_valid, 0);
    chk($sformatf("grant_%0d", g), req_ready, 32'(1 << g));
    tick();
    req_valid[g] = 1'b0;
    @(negedge clk);
    chk("mul_busy", busy, 1);
    chk("mul_req_ready", req_ready, 0);
    chk("mul_resp_valid", resp_valid, 0);
    tick();
    @(negedge clk);
    chk($sformatf("resp_valid_%0d", g), resp_valid, 32'(1 << g));
    chk($sformatf("resp_data_%0d", g), resp_data, p);
    chk("resp_req_ready", req_ready, 0);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_lhs    = '0;
    req_rhs    = '0;
    resp_ready = 4'b1111;
    // All four valid from reset: 1*1, 2*2, 3*3, 4*4.
    set_req(0, 4'd1, 4'd1);
    set_req(1, 4'd2, 4'd2);
    set_req(2, 4'd3, 4'd3);
    set_req(3, 4'd4, 4'd4);
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    tick();
    reset = 1'b0;

    // Contention: served 0,1,2,3 then pointer wraps to 0.
    serve(0, 8'h01);
    serve(1, 8'h04);
    serve(2, 8'h09);
    serve(3, 8'h10);
    set_req(1, 4'd5, 4'd5);
    set_req(0, 4'd6, 4'd6);
    serve(0, 8'h24);
    serve(1, 8'h19);

    // Max operands on requester 2, then zero operand.
    set_req(2, 4'd15, 4'd15);
    serve(2, 8'hE1);
    set_req(2, 4'd0, 4'd15);
    serve(2, 8'h00);

    // After serving 2, requesters 1 and 3 together: 3 goes first.
    set_req(1, 4'd2, 4'd3);
    set_req(3, 4'd4, 4'd5);
    serve(3, 8'h14);
    serve(1, 8'h06);

    // Single request from requester 0 (pointer at 2, search wraps to 0).
    set_req(0, 4'd2, 4'd3);
    serve(0, 8'h06);

    // Backpressure: 7*9 for requester 1 with its resp_ready low, requester 0 waiting.
    set_req(1, 4'd7, 4'd9);
    set_req(0, 4'd8, 4'd8);
    resp_ready = 4'b1101;
    @(negedge clk);
    chk("bp_grant_1", req_ready, 32'h2);
    tick();
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_mul_busy", busy, 1);
    chk("bp_mul_req_ready", req_ready, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid_%0d", k), resp_valid, 32'h2);
      chk($sformatf("bp_hold_data_%0d", k), resp_data, 32'h3F);
      chk($sformatf("bp_hold_ready_%0d", k), req_ready, 0);
      tick();
    end
    resp_ready = 4'b1111;
    @(negedge clk);
    chk("bp_release_valid", resp_valid, 32'h2);
    chk("bp_release_ready", req_ready, 0);
    tick();
    serve(0, 8'h40);

    // Reset during MUL of 3*5 on requester 2 (pointer at 1 -> grant 2).
    set_req(2, 4'd3, 4'd5);
    @(negedge clk);
    chk("rm_grant_2", req_ready, 32'h4);
    tick();
    req_valid[2] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rm_mul_busy", busy, 1);
    chk("rm_mul_req_ready", req_ready, 0);
    tick();
    // Requesters 0 and 3 wait; pointer must be back at 0 after reset.
    set_req(0, 4'd3, 4'd5);
    set_req(3, 4'd1, 4'd2);
    @(negedge clk);
    chk("rm_busy", busy, 0);
    chk("rm_resp_valid", resp_valid, 0);
    chk("rm_req_ready_forced", req_ready, 0);
    chk("rm_resp_data", resp_data, 0);
    tick();
    reset = 1'b0;
    serve(0, 8'h0F);
    serve(3, 8'h02);
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one FastMult unsigned multiplier among N requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, registers the operands into the shared FastMult instance, registers the product, and returns it to the granted requester with a valid/ready handshake. It sits between multiply-issuing clients and the single multiplier datapath.

## Interface

- N, default 4: number of requesters, 2..16.
- WIDTH, default 4: operand width; product width is 2*WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  bit i: requester i has an operand pair pending.
- req_lhs  in  N*WIDTH  requester i's lhs in bits [i*WIDTH +: WIDTH].
- req_rhs  in  N*WIDTH  requester i's rhs in bits [i*WIDTH +: WIDTH].
- req_ready  out  N  one-hot or zero; bit i set means requester i's request is accepted this cycle.
- resp_valid  out  N  one-hot or zero; bit i set means resp_data belongs to requester i.
- resp_ready  in  N  bit i: requester i consumes its response this cycle.
- resp_data  out  2*WIDTH  registered product, shared by all requesters.
- busy  out  1  high whenever state is not IDLE.

## Operation

- FSM has three states: IDLE, MUL and RESP.
- Registers: state, rr_ptr (log2 N bits), owner id, lhs_q, rhs_q, resp_data.
- IDLE:
  - grant = first i with req_valid[i]=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping mod N).
  - req_ready[grant]=1 combinationally. All other req_ready bits are 0. If no req_valid, all are 0.
  - On a handshake (req_valid[grant] & req_ready[grant]): lhs_q/rhs_q <= grant's operands; owner <= grant; rr_ptr <= (grant+1) mod N; state <= MUL.
- MUL:
  - FastMult computes lhs_q*rhs_q.
  - resp_data <= product; state <= RESP.
  - req_ready = 0.
- RESP:
  - resp_valid[owner]=1 and resp_data is held stable.
  - When resp_ready[owner]=1: state <= IDLE. resp_data keeps its value; it is don't-care when no resp_valid bit is set.
  - resp_ready bits of non-owners are ignored.
- Arithmetic: unsigned, full 2*WIDTH product, no truncation or overflow is possible.
- Requesters must hold req_valid and their operands stable until their req_ready pulse. The arbiter never drops a pending request.
- rr_ptr advances only on an accepted request. Pointer wrap-around from N-1 goes to 0.
- Fairness: with all N requesters continuously valid, each is served exactly once per N transactions.

## Timing

- Reset values: state=IDLE, rr_ptr=0, owner=0, lhs_q=rhs_q=0, resp_data=0, req_ready=0, resp_valid=0, busy=0.
- req_ready is forced to 0 in any cycle where reset=1.
- Latency: request accepted at edge t (IDLE). MUL occupies cycle t..t+1. resp_valid is high from edge t+2.
- Minimum occupancy is 3 cycles per transaction (IDLE accept, MUL, RESP with immediate resp_ready). A new accept cannot occur in the same cycle as a response handshake.
- Response backpressure: the arbiter stays in RESP indefinitely while resp_ready[owner]=0. No new request is accepted during that time.
- A new request that arrives during MUL/RESP waits. It is eligible in the first IDLE cycle.
- Simultaneous valid requests are resolved only by rr_ptr. There is no fixed priority.
- Reset asserted mid-transaction (MUL or RESP) aborts it. Next cycle: IDLE, no resp_valid, rr_ptr=0, and the in-flight result is lost.
- busy=1 exactly in MUL and RESP.

## Test plan

- Single request: requester 0 sends lhs=2, rhs=3, resp_ready held 1 -> req_ready[0] pulses one cycle. Two edges later, resp_valid=0001 and resp_data=0x06. Back to IDLE the next cycle.
- Max operands: requester 2 sends 15*15 -> resp_data=0xE1 (225) with resp_valid=0100. Also 0*15 -> 0x00.
- Contention: all four valid from reset, with distinct operands (1*1, 2*2, 3*3, 4*4) -> served in order 0,1,2,3 with results 1,4,9,16. rr_ptr wraps to 0. A fifth request from 1 (5*5) and 0 (6*6) raised together -> 0 is served first (36), then 1 (25).
- Pointer fairness: after serving requester 2, requesters 1 and 3 raised simultaneously -> requester 3 is granted first.
- Backpressure: requester 1 sends 7*9 with resp_ready[1]=0 for 5 cycles while requester 0 is valid -> resp_valid=0010 and resp_data=0x3F are stable throughout, and req_ready stays 0. After resp_ready[1] rises, requester 0 is accepted in the following IDLE cycle.
- Reset mid-operation: assert reset during MUL of 3*5 -> next cycle busy=0, resp_valid=0, req_ready=0. No response for 3*5 ever appears. After release, a new 3*5 returns 0x0F.
